fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq.sv | 145 ++++++++++++++
 tb/tb_fir_mac_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter that uses one multiply-accumulate unit.
// Each accepted sample takes NTAPS MAC cycles and one output cycle.
module fir_mac_seq #(
    parameter int NTAPS = 4,
    parameter int XW    = 8,
    parameter int CW    = 4,
    parameter int YW    = 16,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x_in,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [CW-1:0] coef_in,
    input  logic          coef_load,
    output logic [YW-1:0] y_out,
    output logic          y_valid,
    output logic          busy
);

    localparam int KW = $clog2(NTAPS);
    localparam int PW = XW + CW;
    localparam int AW = XW + CW + $clog2(NTAPS);
    localparam int SW = ((AW > YW) ? AW : YW) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);
    localparam logic [YW-1:0] Y_MAX  = {1'b0, {(YW-1){1'b1}}};
    localparam logic [YW-1:0] Y_MIN  = {1'b1, {(YW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [KW-1:0]         k_reg;
    logic signed [AW-1:0]  acc_reg;
    logic [YW-1:0]         y_reg;
    logic                  y_valid_reg;

    logic signed [XW-1:0]  d_vec [NTAPS];
    logic signed [CW-1:0]  c_vec [NTAPS];

    logic                  accept;
    logic                  coef_shift;
    logic signed [XW-1:0]  d_sel;
    logic signed [CW-1:0]  c_sel;
    logic signed [PW-1:0]  d_ext, c_ext, prod;
    logic signed [AW-1:0]  acc_shifted;
    logic signed [SW-1:0]  acc_wide, y_max_wide, y_min_wide;
    logic [YW-1:0]         y_next;

    assign x_ready    = (state_reg == IDLE) && !coef_load;
    assign accept     = x_valid && x_ready;
    assign coef_shift = (state_reg == IDLE) && coef_load;
    assign busy       = (state_reg != IDLE);
    assign y_out      = y_reg;
    assign y_valid    = y_valid_reg;

    // Delay line and coefficient chain: one register pair per tap.
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap
            logic signed [XW-1:0] d_reg, d_src;
            logic signed [CW-1:0] c_reg, c_src;

            if (gi == 0) begin : g_head
                assign d_src = x_in;
                assign c_src = coef_in;
            end else begin : g_body
                assign d_src = d_vec[gi-1];
                assign c_src = c_vec[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    d_reg <= '0;
                    c_reg <= (gi == 0) ? CW'(1) : CW'(0);
                end else begin
                    if (accept)
                        d_reg <= d_src;
                    if (coef_shift)
                        c_reg <= c_src;
                end
            end

            assign d_vec[gi] = d_reg;
            assign c_vec[gi] = c_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (k_reg == K_LAST) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign d_sel = d_vec[k_reg];
    assign c_sel = c_vec[k_reg];
    assign d_ext = {{CW{d_sel[XW-1]}}, d_sel};
    assign c_ext = {{XW{c_sel[CW-1]}}, c_sel};
    assign prod  = d_ext * c_ext;

    // Compare in a width that holds both the shifted accumulator and the output limits.
    assign acc_shifted = acc_reg >>> SHIFT;
    assign acc_wide    = {{(SW-AW){acc_shifted[AW-1]}}, acc_shifted};
    assign y_max_wide  = {{(SW-YW+1){1'b0}}, {(YW-1){1'b1}}};
    assign y_min_wide  = {{(SW-YW+1){1'b1}}, {(YW-1){1'b0}}};

    always_comb begin
        y_next = acc_wide[YW-1:0];
        if (acc_wide > y_max_wide)
            y_next = Y_MAX;
        else if (acc_wide < y_min_wide)
            y_next = Y_MIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            acc_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            y_valid_reg <= (state_reg == OUT);
            if (accept) begin
                k_reg   <= '0;
                acc_reg <= '0;
            end else if (state_reg == CALC) begin
                k_reg   <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
                acc_reg <= acc_reg + {{(AW-PW){prod[PW-1]}}, prod};
            end
            if (state_reg == OUT)
                y_reg <= y_next;
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: three instances (default, YW=10, SHIFT=2) share one stimulus
// and are checked every cycle against a timeline model plus literal expectations.
module tb_fir_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x_in;
    logic        x_valid;
    logic [3:0]  coef_in;
    logic        coef_load;

    logic        rdy0, rdy1, rdy2;
    logic        yv0, yv1, yv2;
    logic        busy0, busy1, busy2;
    logic [15:0] y0;
    logic [9:0]  y1;
    logic [15:0] y2;

    always #5 clk = ~clk;

    fir_mac_seq u0 (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(rdy0),
        .coef_in(coef_in), .coef_load(coef_load), .y_out(y0), .y_valid(yv0), .busy(busy0)
    );

    fir_mac_seq #(.YW(10)) u1 (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(rdy1),
        .coef_in(coef_in), .coef_load(coef_load), .y_out(y1), .y_valid(yv1), .busy(busy1)
    );

    fir_mac_seq #(.SHIFT(2)) u2 (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(rdy2),
        .coef_in(coef_in), .coef_load(coef_load), .y_out(y2), .y_valid(yv2), .busy(busy2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected output for one instance: arithmetic shift then clamp to YW bits.
    function automatic int fir_expect(input int sum, input int sh, input int yw);
        int v, hi, lo;
        v  = sum >>> sh;
        hi = (1 << (yw - 1)) - 1;
        lo = -(1 << (yw - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    localparam int NT = 4;
    int  sh_of [3] = '{0, 0, 2};
    int  yw_of [3] = '{16, 10, 16};

    int  mc [NT];
    int  md [NT];
    int  pend [3];
    int  exp_y [3];
    int  edge_n = 0;
    int  busy_until = 0;
    int  yv_edge = -1;
    int  sum;
    bit  exp_valid = 1'b0;
    bit  exp_busy = 1'b0;
    bit  model_ok = 1'b0;
    bit  idle;

    // Model: a sample accepted at edge e is answered at edge e+NT+1 and the
    // filter is free again from edge e+NT+2 on.
    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            model_ok   = 1'b1;
            busy_until = edge_n;
            yv_edge    = -1;
            exp_valid  = 1'b0;
            for (int i = 0; i < 3; i++) exp_y[i] = 0;
            for (int k = 0; k < NT; k++) begin
                md[k] = 0;
                mc[k] = (k == 0) ? 1 : 0;
            end
        end else if (model_ok) begin
            idle      = (edge_n > busy_until);
            exp_valid = (edge_n == yv_edge);
            if (exp_valid)
                for (int i = 0; i < 3; i++) exp_y[i] = pend[i];
            if (idle && coef_load) begin
                for (int k = NT - 1; k > 0; k--) mc[k] = mc[k-1];
                mc[0] = $signed(coef_in);
            end else if (idle && x_valid) begin
                for (int k = NT - 1; k > 0; k--) md[k] = md[k-1];
                md[0] = $signed(x_in);
                sum = 0;
                for (int k = 0; k < NT; k++) sum += mc[k] * md[k];
                for (int i = 0; i < 3; i++) pend[i] = fir_expect(sum, sh_of[i], yw_of[i]);
                busy_until = edge_n + NT + 1;
                yv_edge    = busy_until;
            end
        end
        exp_busy = model_ok && (edge_n < busy_until);
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("y_valid0", int'(yv0), int'(exp_valid));
            chk("y_valid1", int'(yv1), int'(exp_valid));
            chk("y_valid2", int'(yv2), int'(exp_valid));
            chk("y_out0", $signed(y0), exp_y[0]);
            chk("y_out1", $signed(y1), exp_y[1]);
            chk("y_out2", $signed(y2), exp_y[2]);
            chk("busy0", int'(busy0), int'(exp_busy));
            chk("busy1", int'(busy1), int'(exp_busy));
            chk("busy2", int'(busy2), int'(exp_busy));
            chk("x_ready0", int'(rdy0), int'(!exp_busy && !coef_load));
            chk("x_ready1", int'(rdy1), int'(!exp_busy && !coef_load));
            chk("x_ready2", int'(rdy2), int'(!exp_busy && !coef_load));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        int v [4];
        v = '{a, b, c, d};
        coef_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coef_in = v[i][3:0];
            step();
        end
        coef_load = 1'b0;
    endtask

    // Offer one sample, wait for its result and check it against literals.
    task automatic xfer(input int x, input int e0, input int e1, input int e2);
        int got, lat;
        x_in = x[7:0];
        x_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rdy0) begin
                got = 1;
                break;
            end
        end
        chk("accept_timeout", got, 1);
        @(posedge clk);
        #2;
        x_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (yv0) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, 6);
        chk("lit_y0", $signed(y0), e0);
        chk("lit_y1", $signed(y1), e1);
        chk("lit_y2", $signed(y2), e2);
        $display("[TB] x=%0d y0=%0d y1=%0d y2=%0d latency=%0d", x,
                 $signed(y0), $signed(y1), $signed(y2), lat);
        step();
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        x_in = '0;
        x_valid = 1'b0;
        coef_in = '0;
        coef_load = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("reset_y_out", int'(y0), 0);
        chk("reset_y_valid", int'(yv0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_x_ready", int'(rdy0), 1);

        // Pass-through after reset
        xfer(5, 5, 5, 1);
        xfer(0, 0, 0, 0);
        xfer(0, 0, 0, 0);

        // Impulse response with c0..c3 = 1..4
        do_reset();
        load(4, 3, 2, 1);
        xfer(10, 10, 10, 2);
        xfer(0, 20, 20, 5);
        xfer(0, 30, 30, 7);
        xfer(0, 40, 40, 10);
        xfer(0, 0, 0, 0);

        // coef_load wins over x_valid in IDLE
        do_reset();
        x_in = 8'd3;
        x_valid = 1'b1;
        coef_in = 4'd2;
        coef_load = 1'b1;
        @(negedge clk);
        chk("ready_while_load", int'(rdy0), 0);
        @(posedge clk);
        #2;
        coef_load = 1'b0;
        xfer(3, 6, 6, 1);

        // Saturation on the YW=10 instance
        do_reset();
        load(7, 7, 7, 7);
        xfer(127, 889, 511, 222);
        xfer(127, 1778, 511, 444);
        xfer(127, 2667, 511, 666);
        xfer(127, 3556, 511, 889);
        xfer(-128, 1771, 511, 442);
        xfer(-128, -14, -14, -4);
        xfer(-128, -1799, -512, -450);
        xfer(-128, -3584, -512, -896);

        // Reset aborts an in-flight computation
        do_reset();
        x_in = 8'd9;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            cnt += int'(yv0);
        end
        chk("no_y_valid_after_abort", cnt, 0);
        step();
        xfer(3, 3, 3, 0);

        // Arithmetic shift on the SHIFT=2 instance
        do_reset();
        load(1, 1, 1, 1);
        xfer(8, 8, 8, 2);
        xfer(8, 16, 16, 4);
        xfer(8, 24, 24, 6);
        xfer(8, 32, 32, 8);
        do_reset();
        xfer(-5, -5, -5, -2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
